// File: rtl/kernel3_gmem_a_m_axi_fifo_prog.sv
// First-word-fall-through FIFO: a circular storage array of DEPTH-1 words feeding one
// output register, with an occupancy count, registered almost flags and sticky error flags.
module kernel3_gmem_a_m_axi_fifo_prog #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32,
  parameter int AF_LEVEL   = 28,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_en,
  input  logic                  if_flush,
  output logic                  if_full_n,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic                  if_almost_full,
  output logic                  if_almost_empty,
  output logic                  if_overflow,
  output logic                  if_underflow
);

  localparam int                  SDEPTH   = DEPTH - 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(SDEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_CNT   = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AE_CNT   = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [SDEPTH];
  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic                  out_valid;
  logic [ADDR_WIDTH:0]   stor_cnt, cnt_nxt;
  logic                  live, wr_ok, rd_ok, stor_empty, bypass, push, pop;

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_ONE;
  endfunction

  assign live       = clk_en & ~if_flush;
  assign if_full_n  = (if_num_data_valid != FULL_CNT);
  assign if_empty_n = out_valid;
  assign wr_ok      = live & if_write & if_full_n;
  assign rd_ok      = live & if_read & out_valid;
  assign stor_cnt   = if_num_data_valid - {{ADDR_WIDTH{1'b0}}, out_valid};
  assign stor_empty = (stor_cnt == '0);
  // Head word being consumed with nothing queued behind it: the incoming word goes
  // straight to the output register so the read side never sees a bubble.
  assign bypass     = wr_ok & rd_ok & stor_empty;
  assign push       = wr_ok & ~bypass;
  assign pop        = live & ~stor_empty & (~out_valid | rd_ok);

  always_comb begin
    cnt_nxt = if_num_data_valid;
    if (wr_ok && !rd_ok)
      cnt_nxt = if_num_data_valid + CNT_ONE;
    else if (rd_ok && !wr_ok)
      cnt_nxt = if_num_data_valid - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= if_din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr              <= '0;
      rptr              <= '0;
      out_valid         <= 1'b0;
      if_dout           <= '0;
      if_num_data_valid <= '0;
      if_almost_full    <= 1'b0;
      if_almost_empty   <= 1'b1;
      if_overflow       <= 1'b0;
      if_underflow      <= 1'b0;
    end else if (clk_en) begin
      if (if_flush) begin
        wptr              <= '0;
        rptr              <= '0;
        out_valid         <= 1'b0;
        if_num_data_valid <= '0;
        if_almost_full    <= 1'b0;
        if_almost_empty   <= 1'b1;
        if_overflow       <= 1'b0;
        if_underflow      <= 1'b0;
      end else begin
        if (push)
          wptr <= ptr_inc(wptr);
        if (pop) begin
          rptr      <= ptr_inc(rptr);
          if_dout   <= mem[rptr];
          out_valid <= 1'b1;
        end else if (bypass) begin
          if_dout <= if_din;
        end else if (rd_ok) begin
          out_valid <= 1'b0;
        end
        if_num_data_valid <= cnt_nxt;
        if_almost_full    <= (cnt_nxt >= AF_CNT);
        if_almost_empty   <= (cnt_nxt <= AE_CNT);
        if (if_write && !if_full_n)
          if_overflow <= 1'b1;
        if (if_read && !out_valid)
          if_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kernel3_gmem_a_m_axi_fifo_prog.sv
// Scoreboard bench for the FWFT FIFO at DEPTH=4, AF_LEVEL=3, AE_LEVEL=1, DATA_WIDTH=8.
module tb_kernel3_gmem_a_m_axi_fifo_prog;
  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset_n, clk_en, if_flush, if_write, if_read;
  logic [DW-1:0] if_din, if_dout;
  logic          if_full_n, if_empty_n, if_almost_full, if_almost_empty, if_overflow, if_underflow;
  logic [AW:0]   if_num_data_valid;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] expq[$];

  always #5 clk = ~clk;

  kernel3_gmem_a_m_axi_fifo_prog #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .if_flush(if_flush),
    .if_full_n(if_full_n), .if_write(if_write), .if_din(if_din),
    .if_empty_n(if_empty_n), .if_read(if_read), .if_dout(if_dout),
    .if_num_data_valid(if_num_data_valid), .if_almost_full(if_almost_full),
    .if_almost_empty(if_almost_empty), .if_overflow(if_overflow), .if_underflow(if_underflow)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int cnt, input logic full_n, input logic empty_n,
                           input logic af, input logic ae, input logic ov, input logic un);
    check({tag, ".count"},   32'(if_num_data_valid), 32'(cnt));
    check({tag, ".full_n"},  32'(if_full_n),  32'(full_n));
    check({tag, ".empty_n"}, 32'(if_empty_n), 32'(empty_n));
    check({tag, ".af"},      32'(if_almost_full),  32'(af));
    check({tag, ".ae"},      32'(if_almost_empty), 32'(ae));
    check({tag, ".ovf"},     32'(if_overflow),  32'(ov));
    check({tag, ".unf"},     32'(if_underflow), 32'(un));
  endtask

  // One clock: drive inputs, let the edge happen, return 1 ns after it. acc says whether
  // the write is known (by hand) to be accepted, in which case its data is expected later.
  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic f, input logic acc);
    if_write = w; if_din = d; if_read = r; if_flush = f;
    if (acc) expq.push_back(d);
    @(posedge clk);
    #1;
    if_write = 1'b0; if_read = 1'b0; if_flush = 1'b0;
  endtask

  // Monitor: every accepted read must present the oldest expected word.
  always @(negedge clk) begin
    if (reset_n && clk_en && !if_flush && if_read && if_empty_n) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_data unexpected read actual=%h required=none", if_dout);
      end else begin
        check("rd_data", 32'(if_dout), 32'(expq.pop_front()));
      end
    end
  end

  initial begin
    reset_n = 1'b0; clk_en = 1'b1; if_flush = 1'b0; if_write = 1'b0; if_read = 1'b0; if_din = '0;
    #12;
    chk_state("reset", 0, 1, 0, 0, 1, 0, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // single write latency
    cyc(1, 8'h11, 0, 0, 1); chk_state("w1_edge0", 1, 1, 0, 0, 1, 0, 0);
    cyc(0, 8'h00, 0, 0, 0); chk_state("w1_edge1", 1, 1, 1, 0, 1, 0, 0);
    check("w1_dout", 32'(if_dout), 32'h11);
    cyc(0, 8'h00, 1, 0, 0); chk_state("w1_read", 0, 1, 0, 0, 1, 0, 0);

    // fill past full, then drain
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 8'(i), 0, 0, i <= 4);
      chk_state($sformatf("fill%0d", i), (i < 4) ? i : 4, i < 4, i > 1, i >= 3, i == 1, i == 5, 0);
    end
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 8'h00, 1, 0, 0);
      chk_state($sformatf("drain%0d", i), 4 - i, 1, i < 4, i == 1, i >= 3, 1, 0);
    end

    // underflow then flush
    cyc(0, 8'h00, 1, 0, 0); chk_state("under", 0, 1, 0, 0, 1, 1, 1);
    cyc(0, 8'h00, 0, 1, 0); chk_state("flush", 0, 1, 0, 0, 1, 0, 0);

    // streaming with two words held
    cyc(1, 8'hA0, 0, 0, 1);
    cyc(1, 8'hA1, 0, 0, 1); chk_state("pre_stream", 2, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 8'(8'hB0 + i), 1, 0, 1);
      chk_state($sformatf("stream%0d", i), 2, 1, 1, 0, 0, 0, 0);
    end
    cyc(0, 8'h00, 1, 0, 0);
    cyc(0, 8'h00, 1, 0, 0); chk_state("post_stream", 0, 1, 0, 0, 1, 0, 0);

    // simultaneous write and read with one word held
    cyc(1, 8'h55, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 0);
    cyc(1, 8'h66, 1, 0, 1); chk_state("simul1", 1, 1, 1, 0, 1, 0, 0);
    check("simul1_dout", 32'(if_dout), 32'h66);
    cyc(0, 8'h00, 1, 0, 0); chk_state("simul1_drain", 0, 1, 0, 0, 1, 0, 0);

    // flush overrides a same-cycle write and read
    cyc(1, 8'h44, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);
    cyc(1, 8'h99, 1, 1, 0); chk_state("flush_ovr", 0, 1, 0, 0, 1, 0, 0);

    // clk_en low holds everything
    cyc(1, 8'h21, 0, 0, 1);
    cyc(1, 8'h22, 0, 0, 1);
    cyc(1, 8'h23, 0, 0, 1); chk_state("pre_hold", 3, 1, 1, 1, 0, 0, 0);
    check("pre_hold_dout", 32'(if_dout), 32'h21);
    clk_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 8'(8'h30 + i), 1, 0, 0);
      chk_state($sformatf("hold%0d", i), 3, 1, 1, 1, 0, 0, 0);
      check($sformatf("hold%0d_dout", i), 32'(if_dout), 32'h21);
    end
    clk_en = 1'b1;

    // reset in the middle of a burst
    cyc(1, 8'h24, 1, 0, 1);
    if_write = 1'b1; if_read = 1'b1; if_din = 8'h25;
    #2 reset_n = 1'b0;
    #1 chk_state("rst_mid", 0, 1, 0, 0, 1, 0, 0);
    expq.delete();
    if_write = 1'b0; if_read = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk_state("rst_rel", 0, 1, 0, 0, 1, 0, 0);
    cyc(1, 8'h77, 0, 0, 1); chk_state("after_rst0", 1, 1, 0, 0, 1, 0, 0);
    cyc(0, 8'h00, 0, 0, 0); chk_state("after_rst1", 1, 1, 1, 0, 1, 0, 0);
    check("after_rst_dout", 32'(if_dout), 32'h77);
    cyc(0, 8'h00, 1, 0, 0); chk_state("after_rst_rd", 0, 1, 0, 0, 1, 0, 0);

    check("leftover", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kernel3_gmem_a_m_axi_fifo_prog.md
KERNEL3_GMEM_A_M_AXI_FIFO_PROG -- requirements
Module: kernel3_gmem_A_m_axi_fifo_prog

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, log2 of DEPTH.
REQ-003 The block SHALL have parameter DEPTH, default 32, total word capacity, legal range 2..2^ADDR_WIDTH.
REQ-004 The block SHALL have parameter AF_LEVEL, default 28, almost-full threshold, legal range 1..DEPTH.
REQ-005 The block SHALL have parameter AE_LEVEL, default 2, almost-empty threshold, legal range 0..DEPTH-1.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 clk_en  input  1  state-update enable; when low, all registers hold.
REQ-009 if_flush  input  1  synchronous clear of contents and sticky flags.
REQ-010 if_full_n  output  1  high when a write will be accepted.
REQ-011 if_write  input  1  write request.
REQ-012 if_din  input  DATA_WIDTH  write data.
REQ-013 if_empty_n  output  1  high when if_dout holds valid data.
REQ-014 if_read  input  1  read request / consume current if_dout.
REQ-015 if_dout  output  DATA_WIDTH  first-word-fall-through read data.
REQ-016 if_num_data_valid  output  ADDR_WIDTH+1  words held, 0..DEPTH.
REQ-017 if_almost_full  output  1  registered, count >= AF_LEVEL.
REQ-018 if_almost_empty  output  1  registered, count <= AE_LEVEL.
REQ-019 if_overflow  output  1  sticky: write attempted while full.
REQ-020 if_underflow  output  1  sticky: read attempted while empty.

Function
REQ-021 A write SHALL be accepted when if_write & if_full_n & clk_en; a read SHALL be accepted when if_read & if_empty_n & clk_en.
REQ-022 Accepted words SHALL leave in write order, none lost or duplicated.
REQ-023 The block SHALL be first-word-fall-through: storage array plus one output register; the head word is prefetched into the output register whenever it is empty or being consumed.
REQ-024 Latency: into an empty FIFO, a write accepted at edge N SHALL give if_empty_n=1 and that word on if_dout after edge N+1 (two clk_en edges incl. N).
REQ-025 if_num_data_valid SHALL be +1 on write-only, -1 on read-only, unchanged on simultaneous accepted write and read or neither.
REQ-026 if_full_n SHALL be 0 exactly when count = DEPTH; simultaneous write and read when full SHALL be impossible (write refused) and the read SHALL proceed.
REQ-027 Simultaneous write and read with one word held SHALL keep if_empty_n=1 with the new word on if_dout next cycle.
REQ-028 if_dout SHALL hold its value while if_empty_n=1 and no read is accepted.
REQ-029 Storage pointers SHALL wrap modulo the storage depth without gaps for non-power-of-two DEPTH.
REQ-030 if_almost_full/if_almost_empty SHALL update on the same edge as the count, from the post-update count.
REQ-031 if_overflow SHALL set on if_write & !if_full_n & clk_en; if_underflow on if_read & !if_empty_n & clk_en; both hold until flush or reset.
REQ-032 if_flush & clk_en SHALL, in one edge, empty the FIFO, clear both sticky flags, and override any same-cycle write or read (neither accepted, no flag set).
REQ-033 DEPTH=2 SHALL work with storage of one word plus the output register.

Reset
REQ-034 While reset_n=0, regardless of clk and clk_en: if_full_n=1, if_empty_n=0, if_num_data_valid=0, if_almost_full=0, if_almost_empty=1, if_overflow=0, if_underflow=0; if_dout value is don't-care.
REQ-035 Reset asserted mid-transfer SHALL discard all contents; first write after release behaves as on an empty FIFO.

Verification (DEPTH=4, AF_LEVEL=3, AE_LEVEL=1, DATA_WIDTH=8)
REQ-036 Write 0x11 once into empty FIFO -> if_empty_n=1, if_dout=0x11 two edges later, count=1, almost_empty=1.
REQ-037 Write 0x01..0x05 back-to-back, no reads -> 4 accepted, if_full_n=0 after 4th, almost_full=1 after 3rd, overflow=1 after 5th attempt; drain reads 0x01..0x04 in order.
REQ-038 Continuous write and read with 2 words held for 20 cycles -> count stays 2, output sequence equals input sequence, no flags.
REQ-039 Read with FIFO empty -> underflow=1, count stays 0; then if_flush -> underflow=0.
REQ-040 Fill 3 words, hold clk_en=0 for 5 cycles with if_write=if_read=1 -> no state change; deassert reset_n mid-burst -> all outputs at REQ-034 values immediately.
